// File: rtl/ace_pkg.sv
// ace_pkg: shared types and ACE encodings for the coherent request issuer.
package ace_pkg;

    typedef enum logic [2:0] {
        LS_UC = 3'b001,
        LS_SC = 3'b010,
        LS_UD = 3'b011,
        LS_I  = 3'b100,
        LS_SD = 3'b101
    } line_state_t;

    localparam logic [3:0] ARSNOOP_READ_SHARED  = 4'b0001;
    localparam logic [3:0] ARSNOOP_READ_UNIQUE  = 4'b0111;
    localparam logic [3:0] ARSNOOP_CLEAN_UNIQUE = 4'b1011;

    localparam logic [1:0] ARDOMAIN_INNER = 2'b01;

    localparam int RRESP_IS_SHARED  = 3;
    localparam int RRESP_PASS_DIRTY = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ACK
    } issuer_state_t;

endpackage

// File: rtl/ace_resp_decode.sv
// ace_resp_decode: maps the issued snoop type and R-beat response to the new line state.
module ace_resp_decode
    import ace_pkg::*;
(
    input  logic [3:0]  arsnoop,
    input  logic [3:0]  rresp,
    input  logic        rlast,
    output line_state_t state,
    output logic        error
);

    logic shared;
    logic dirty;

    always_comb begin
        error  = (rresp[1:0] != 2'b00) || !rlast;
        shared = rresp[RRESP_IS_SHARED];
        dirty  = rresp[RRESP_PASS_DIRTY];
        // ReadUnique ignores IsShared; CleanUnique always ends unique-clean
        state  = error                                ? LS_I  :
                 (arsnoop == ARSNOOP_CLEAN_UNIQUE)    ? LS_UC :
                 (arsnoop == ARSNOOP_READ_UNIQUE)     ? (dirty ? LS_UD : LS_UC) :
                 (shared && dirty)                    ? LS_SD :
                 shared                               ? LS_SC :
                 dirty                                ? LS_UD : LS_UC;
    end

endmodule

// File: rtl/ace_req_issuer.sv
// ace_req_issuer: turns cache-controller request pulses into ACE AR/R/RACK transactions
// with a response watchdog, returning fill data and the new line state.
module ace_req_issuer
    import ace_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 64,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_req,
    input  logic              write_req,
    input  logic              invalid_req,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              busy,
    output logic              ace_ready,
    output logic              ace_error,
    output logic [LINE_W-1:0] rd_data,
    output logic [2:0]        resp_state,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arsnoop,
    output logic [1:0]        ardomain,
    output logic              arvalid,
    input  logic              arready,
    input  logic              rvalid,
    output logic              rready,
    input  logic [LINE_W-1:0] rdata,
    input  logic [3:0]        rresp,
    input  logic              rlast,
    output logic              rack
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    issuer_state_t     state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [3:0]        arsnoop_q, arsnoop_d;
    logic [LINE_W-1:0] rd_data_q, rd_data_d;
    line_state_t       resp_state_q, resp_state_d, dec_state;
    logic              err_q, err_d, dec_err;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              any_req, beat, expire;

    ace_resp_decode u_decode (
        .arsnoop (arsnoop_q),
        .rresp   (rresp),
        .rlast   (rlast),
        .state   (dec_state),
        .error   (dec_err)
    );

    assign any_req = read_req | write_req | invalid_req;
    assign beat    = (state_q == S_DATA) && rvalid;
    // a beat arriving on the expiry cycle takes precedence over the abort
    assign expire  = (state_q == S_DATA) && !rvalid && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = any_req ? S_ADDR : S_IDLE;
            S_ADDR:  state_d = arready ? S_DATA : S_ADDR;
            S_DATA:  state_d = beat ? S_ACK : expire ? S_IDLE : S_DATA;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        araddr_d     = araddr_q;
        arsnoop_d    = arsnoop_q;
        rd_data_d    = rd_data_q;
        resp_state_d = resp_state_q;
        err_d        = err_q;
        wd_d         = (state_q == S_DATA) ? wd_q + WD_W'(1) : '0;
        if (state_q == S_IDLE && any_req) begin
            araddr_d  = req_addr;
            arsnoop_d = invalid_req ? ARSNOOP_CLEAN_UNIQUE :
                        write_req   ? ARSNOOP_READ_UNIQUE  : ARSNOOP_READ_SHARED;
        end
        if (beat) begin
            rd_data_d    = (arsnoop_q == ARSNOOP_CLEAN_UNIQUE) ? rd_data_q : rdata;
            resp_state_d = dec_state;
            err_d        = dec_err;
        end
        if (expire) resp_state_d = LS_I;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            araddr_q     <= '0;
            arsnoop_q    <= '0;
            rd_data_q    <= '0;
            resp_state_q <= LS_I;
            err_q        <= 1'b0;
            wd_q         <= '0;
        end else begin
            araddr_q     <= araddr_d;
            arsnoop_q    <= arsnoop_d;
            rd_data_q    <= rd_data_d;
            resp_state_q <= resp_state_d;
            err_q        <= err_d;
            wd_q         <= wd_d;
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        arvalid    = (state_q == S_ADDR);
        rready     = (state_q == S_DATA);
        rack       = (state_q == S_ACK);
        ace_ready  = rack || expire;
        ace_error  = (rack && err_q) || expire;
        resp_state = expire ? LS_I : resp_state_q;
        rd_data    = rd_data_q;
        araddr     = araddr_q;
        arsnoop    = arsnoop_q;
        ardomain   = ARDOMAIN_INNER;
    end

endmodule

// File: tb/tb_ace_req_issuer.sv
// tb_ace_req_issuer: directed scoreboard bench for the ACE request issuer.
module tb_ace_req_issuer;

    localparam int TO = 8;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  snoop;
        logic [2:0]  state;
        logic        err;
        logic        rk;
        logic        cd;
        logic [63:0] data;
    } exp_t;

    logic        clk = 0, reset = 1;
    logic        read_req = 0, write_req = 0, invalid_req = 0;
    logic [31:0] req_addr = 0;
    logic        busy, ace_ready, ace_error, arvalid, rready, rack;
    logic [63:0] rd_data;
    logic [2:0]  resp_state;
    logic [31:0] araddr;
    logic [3:0]  arsnoop;
    logic [1:0]  ardomain;
    logic        arready = 0, rvalid = 0, rlast = 1;
    logic [63:0] rdata = 0;
    logic [3:0]  rresp = 0;

    int   total = 0, bad = 0;
    exp_t sb[$];

    ace_req_issuer #(.ADDR_W(32), .LINE_W(64), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .read_req(read_req), .write_req(write_req),
        .invalid_req(invalid_req), .req_addr(req_addr), .busy(busy),
        .ace_ready(ace_ready), .ace_error(ace_error), .rd_data(rd_data),
        .resp_state(resp_state), .araddr(araddr), .arsnoop(arsnoop),
        .ardomain(ardomain), .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rack(rack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [3:0] sn, input logic [2:0] st,
                                input logic er, input logic rk, input logic cd, input logic [63:0] d);
        exp_t e;
        e.addr = a; e.snoop = sn; e.state = st; e.err = er; e.rk = rk; e.cd = cd; e.data = d;
        return e;
    endfunction

    task automatic issue(input logic rd, input logic wr, input logic inv, input exp_t e);
        read_req = rd; write_req = wr; invalid_req = inv; req_addr = e.addr;
        sb.push_back(e);
        @(negedge clk);
        read_req = 0; write_req = 0; invalid_req = 0;
    endtask

    task automatic addr_phase(input int stall);
        arready = 0;
        for (int i = 0; i < stall; i++) begin
            chk("arvalid_stall", arvalid, 1);
            chk("araddr_stall", araddr, sb[0].addr);
            @(negedge clk);
        end
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, sb[0].addr);
        chk("arsnoop", arsnoop, sb[0].snoop);
        arready = 1;
        @(negedge clk);
        arready = 0;
        chk("arvalid_drop", arvalid, 0);
    endtask

    task automatic data_phase(input int delay, input logic [63:0] d, input logic [3:0] rr, input logic rl);
        for (int i = 0; i < delay; i++) begin
            chk("rready_wait", rready, 1);
            @(negedge clk);
        end
        chk("rready", rready, 1);
        rvalid = 1; rdata = d; rresp = rr; rlast = rl;
        @(negedge clk);
        rvalid = 0; rlast = 1;
    endtask

    task automatic wait_done(input int bound, input int exp_wait);
        exp_t e;
        int n = 0;
        while (!ace_ready && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ace_ready", ace_ready, 1);
            chk("latency", n, exp_wait);
            chk("ace_error", ace_error, e.err);
            chk("rack", rack, e.rk);
            chk("resp_state", resp_state, e.state);
            if (e.cd) chk("rd_data", rd_data, e.data);
        end
        @(negedge clk);
        chk("ready_pulse", ace_ready, 0);
        chk("rack_pulse", rack, 0);
        chk("busy_fall", busy, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ace_ready, 0);
        chk("rst_error", ace_error, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rack", rack, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_state", resp_state, 3'b100);
        chk("ardomain", ardomain, 2'b01);
        reset = 0;
        @(negedge clk);

        // ReadShared, minimum latency, IsShared -> SC
        issue(1, 0, 0, mk(32'h1000, 4'b0001, 3'b010, 0, 1, 1, 64'hA5A5_0000_1111_2222));
        addr_phase(0);
        data_phase(0, 64'hA5A5_0000_1111_2222, 4'b1000, 1);
        wait_done(4, 0);

        // ReadUnique with AR stall and a request ignored while busy; PassDirty -> UD
        issue(0, 1, 0, mk(32'h2040, 4'b0111, 3'b011, 0, 1, 1, 64'h0123_4567_89AB_CDEF));
        invalid_req = 1; req_addr = 32'hDEAD;
        chk("busy", busy, 1);
        chk("arvalid_stall", arvalid, 1);
        @(negedge clk);
        invalid_req = 0;
        addr_phase(3);
        data_phase(1, 64'h0123_4567_89AB_CDEF, 4'b0100, 1);
        wait_done(4, 0);

        // invalid+read together: CleanUnique only, rd_data kept
        issue(1, 0, 1, mk(32'h3000, 4'b1011, 3'b001, 0, 1, 1, 64'h0123_4567_89AB_CDEF));
        addr_phase(0);
        data_phase(0, 64'hFFFF_EEEE_DDDD_CCCC, 4'b0000, 1);
        wait_done(4, 0);

        // watchdog abort
        issue(1, 0, 0, mk(32'h4000, 4'b0001, 3'b100, 1, 0, 1, 64'h0123_4567_89AB_CDEF));
        addr_phase(0);
        wait_done(TO + 2, TO - 1);

        // SLVERR
        issue(1, 0, 0, mk(32'h5000, 4'b0001, 3'b100, 1, 1, 0, 64'h0));
        addr_phase(0);
        data_phase(0, 64'h5555_5555_5555_5555, 4'b0010, 1);
        wait_done(4, 0);

        // ReadShared IsShared+PassDirty -> SD
        issue(1, 0, 0, mk(32'h6000, 4'b0001, 3'b101, 0, 1, 1, 64'h6666_0000_6666_0000));
        addr_phase(0);
        data_phase(2, 64'h6666_0000_6666_0000, 4'b1100, 1);
        wait_done(4, 0);

        // missing rlast is an error
        issue(0, 1, 0, mk(32'h6800, 4'b0111, 3'b100, 1, 1, 0, 64'h0));
        addr_phase(0);
        data_phase(0, 64'h6868_6868_6868_6868, 4'b0000, 0);
        wait_done(4, 0);

        // reset while in DATA, then a clean transaction
        issue(1, 0, 0, mk(32'h7000, 4'b0001, 3'b001, 0, 1, 1, 64'h0));
        addr_phase(0);
        @(negedge clk);
        reset = 1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ace_ready, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_rack", rack, 0);
        chk("mid_rst_araddr", araddr, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_state", resp_state, 3'b100);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        issue(1, 0, 0, mk(32'h8000, 4'b0001, 3'b001, 0, 1, 1, 64'h8888_1234_8888_5678));
        addr_phase(0);
        data_phase(0, 64'h8888_1234_8888_5678, 4'b0000, 1);
        wait_done(4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ace_req_issuer.md
Name: ace_req_issuer

Overview:
Sits directly downstream of cache_controller. Turns its single-cycle read_req / write_req / invalid_req pulses into ACE read-address-channel coherent transactions:
- read_req -> ReadShared
- write_req -> ReadUnique
- invalid_req -> CleanUnique
It collects the R-channel response, issues RACK, and returns ace_ready together with the fill data and the new line state. It owns the AR/R/RACK handshakes and a response watchdog.

Parameters:
ADDR_W, 32, request/ARADDR width
LINE_W, 64, cache line width; one R beat carries one full line
TIMEOUT_CYC, 256, cycles allowed in DATA before watchdog abort (min 2)

Ports:
clk  in  1  clock; all logic rising-edge
reset  in  1  asynchronous, active-high reset
read_req  in  1  controller pulse: read miss
write_req  in  1  controller pulse: write needs ownership
invalid_req  in  1  controller pulse: upgrade SC->unique, no data
req_addr  in  ADDR_W  line address, sampled with the request
busy  out  1  transaction in flight; new requests ignored
ace_ready  out  1  one-cycle completion pulse to controller
ace_error  out  1  one-cycle pulse: bad RRESP or timeout (coincides with ace_ready)
rd_data  out  LINE_W  fill data; valid from ace_ready until next accept
resp_state  out  3  new line state; valid from ace_ready until next accept
araddr  out  ADDR_W  ACE read address
arsnoop  out  4  ACE snoop type
ardomain  out  2  ACE domain; constant 2'b01 (inner shareable)
arvalid  out  1  AR valid
arready  in  1  AR ready
rvalid  in  1  R valid
rready  out  1  R ready
rdata  in  LINE_W  R data
rresp  in  4  R response: [3] IsShared, [2] PassDirty, [1:0] resp
rlast  in  1  R last; always expected 1
rack  out  1  read acknowledge, one cycle

Behaviour:
- Reset (async, active-high): FSM -> IDLE. All outputs 0, except resp_state = 3'b100 (I).
- FSM states: IDLE, ADDR, DATA, ACK.
- IDLE:
  - Sample requests only here. Priority invalid_req > write_req > read_req; lower-priority simultaneous pulses are dropped.
  - On accept: register araddr = req_addr and arsnoop (ReadShared 4'b0001, ReadUnique 4'b0111, CleanUnique 4'b1011); next state ADDR.
- ADDR:
  - arvalid = 1. araddr/arsnoop stable until arready.
  - arvalid&arready -> DATA. arvalid drops the next cycle.
- DATA:
  - rready = 1. Watchdog counts cycles in DATA.
  - rvalid&rready (rlast must be 1) -> capture rdata (ReadShared/ReadUnique only; CleanUnique leaves rd_data unchanged) and decode resp_state -> ACK.
  - Watchdog reaches TIMEOUT_CYC -> ace_ready = ace_error = 1, resp_state = I, no rack, -> IDLE.
  - rvalid in the same cycle as expiry: the response wins.
- ACK: rack = 1, ace_ready = 1 for exactly one cycle -> IDLE.
- busy = 1 in ADDR/DATA/ACK. Requests arriving while busy are ignored; the controller re-issues.
- Minimum latency: request at cycle 0, arvalid at cycle 1 (arready = 1), rvalid at cycle 2, ace_ready + rack at cycle 3.
- State decode (line encoding: UC 001, SC 010, UD 011, I 100, SD 101):
  - ReadShared: IsShared&PassDirty -> SD; IsShared -> SC; PassDirty -> UD; else UC.
  - ReadUnique: PassDirty -> UD, else UC (IsShared ignored).
  - CleanUnique -> UC.
- Errors:
  - rresp[1:0] != 2'b00, or rlast = 0 on the beat: resp_state = I, ace_error = 1 with ace_ready. rack is still issued.
- Reset mid-transaction: immediate return to IDLE. No rack, no ace_ready, watchdog cleared.

Decomposition:
- Package ace_pkg:
  - line_state_t enum (UC/SC/UD/I/SD encodings)
  - ARSNOOP constants
  - ARDOMAIN constant
  - RRESP bit indices
  - issuer FSM state enum
- One sub-module, ace_resp_decode: combinational (arsnoop, rresp, rlast) -> (line_state_t, error).

Test Plan:
- read_req with addr 0x1000, arready = 1, rvalid at next cycle, rresp = 4'b1000 -> arsnoop 0001, ace_ready at cycle 3, resp_state = SC, rd_data = rdata, rack 1 cycle.
- write_req, arready held 0 for 4 cycles -> arvalid/araddr stable for 5 cycles; response rresp = 4'b0100 -> resp_state = UD.
- invalid_req + read_req in the same cycle -> arsnoop 1011 only; read dropped; resp_state = UC; rd_data unchanged.
- read_req, no rvalid for TIMEOUT_CYC cycles -> ace_ready = ace_error = 1, resp_state = I, rack = 0, busy falls.
- rresp = 4'b0010 (SLVERR) -> ace_error with ace_ready, rack = 1, resp_state = I.
- reset pulsed while in DATA -> all outputs 0, resp_state = I, next read_req completes normally.
